// File: rtl/filter_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : filter_bank_sequencer
//  Description : Schedules one shared external MAC across a three-band
//                (low/mid/high) FIR filter bank. On each sample strobe it
//                writes the history RAM, walks taps x bands, drives RAM and
//                coefficient addresses plus MAC controls, then latches the
//                three saturated band results.
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_bank_sequencer #(
  parameter int WIDTH   = 25,
  parameter int NTAPS   = 8,
  parameter int AW      = 3,
  parameter int MAC_LAT = 2,
  parameter int ACCW    = 53
) (
  input  logic              clock44k,
  input  logic              reset,
  input  logic              enable,
  output logic              busy,
  output logic              overrun,
  output logic              hist_we,
  output logic [AW-1:0]     hist_waddr,
  output logic [AW-1:0]     hist_raddr,
  output logic              tap_valid,
  output logic [AW+1:0]     coef_addr,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic [ACCW-1:0]   acc,
  output logic [WIDTH-1:0]  ykbajos,
  output logic [WIDTH-1:0]  ykmedios,
  output logic [WIDTH-1:0]  ykaltos,
  output logic              done
);

  localparam int               c_dw    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [c_dw-1:0]  c_dlast = c_dw'(MAC_LAT - 1);
  localparam logic [AW-1:0]    c_klast = AW'(NTAPS - 1);
  localparam logic [AW:0]      c_full  = (AW+1)'(NTAPS);
  localparam logic [1:0]       c_blast = 2'd2;

  localparam logic signed [ACCW-1:0] c_sat_hi =
    {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] c_sat_lo =
    {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_b, w_b_nxt;
  logic [AW-1:0]    r_k, w_k_nxt;
  logic [c_dw-1:0]  r_d, w_d_nxt;
  logic [AW-1:0]    r_wptr, w_wptr_nxt;
  logic [AW-1:0]    r_p, w_p_nxt;
  logic [AW:0]      r_fill, w_fill_nxt;

  logic             w_busy_nxt, w_overrun_nxt, w_hist_we_nxt, w_tap_valid_nxt;
  logic             w_mac_en_nxt, w_mac_clr_nxt, w_done_nxt;
  logic [AW-1:0]    w_hist_waddr_nxt, w_hist_raddr_nxt;
  logic [AW+1:0]    w_coef_addr_nxt;
  logic [WIDTH-1:0] w_lo_nxt, w_mid_nxt, w_hi_nxt;

  // Scale the Q.(2W-2) accumulator back to Q1.(W-1) and clamp to the
  // representable range so large band sums pin instead of wrapping.
  logic signed [ACCW-1:0] w_acc_sh;
  logic [WIDTH-1:0]       w_res;
  assign w_acc_sh = $signed(acc) >>> (WIDTH - 1);
  assign w_res    = (w_acc_sh > c_sat_hi) ? c_sat_hi[WIDTH-1:0] :
                    (w_acc_sh < c_sat_lo) ? c_sat_lo[WIDTH-1:0] :
                                            w_acc_sh[WIDTH-1:0];

  // State, counters and every output are registered here.
  always_ff @(posedge clock44k or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_b        <= '0;
      r_k        <= '0;
      r_d        <= '0;
      r_wptr     <= '0;
      r_p        <= '0;
      r_fill     <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      hist_we    <= 1'b0;
      hist_waddr <= '0;
      hist_raddr <= '0;
      tap_valid  <= 1'b0;
      coef_addr  <= '0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      ykbajos    <= '0;
      ykmedios   <= '0;
      ykaltos    <= '0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_b        <= w_b_nxt;
      r_k        <= w_k_nxt;
      r_d        <= w_d_nxt;
      r_wptr     <= w_wptr_nxt;
      r_p        <= w_p_nxt;
      r_fill     <= w_fill_nxt;
      busy       <= w_busy_nxt;
      overrun    <= w_overrun_nxt;
      hist_we    <= w_hist_we_nxt;
      hist_waddr <= w_hist_waddr_nxt;
      hist_raddr <= w_hist_raddr_nxt;
      tap_valid  <= w_tap_valid_nxt;
      coef_addr  <= w_coef_addr_nxt;
      mac_en     <= w_mac_en_nxt;
      mac_clr    <= w_mac_clr_nxt;
      ykbajos    <= w_lo_nxt;
      ykmedios   <= w_mid_nxt;
      ykaltos    <= w_hi_nxt;
      done       <= w_done_nxt;
    end
  end

  // Next state plus the output values belonging to that next state, so the
  // registered outputs line up with the state they describe.
  always_comb begin
    w_state_nxt      = r_state;
    w_b_nxt          = r_b;
    w_k_nxt          = r_k;
    w_d_nxt          = r_d;
    w_wptr_nxt       = r_wptr;
    w_p_nxt          = r_p;
    w_fill_nxt       = r_fill;
    w_overrun_nxt    = overrun | (enable & (r_state != S_IDLE));
    w_hist_we_nxt    = 1'b0;
    w_hist_waddr_nxt = hist_waddr;
    w_hist_raddr_nxt = hist_raddr;
    w_tap_valid_nxt  = 1'b0;
    w_coef_addr_nxt  = coef_addr;
    w_mac_en_nxt     = 1'b0;
    w_mac_clr_nxt    = 1'b0;
    w_done_nxt       = 1'b0;
    w_lo_nxt         = ykbajos;
    w_mid_nxt        = ykmedios;
    w_hi_nxt         = ykaltos;

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt      = S_WRITE;
          w_hist_we_nxt    = 1'b1;
          w_hist_waddr_nxt = r_wptr;
          w_p_nxt          = r_wptr;
          w_wptr_nxt       = r_wptr + 1'b1;
          w_fill_nxt       = (r_fill == c_full) ? r_fill : r_fill + 1'b1;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_RUN;
        w_b_nxt     = '0;
        w_k_nxt     = '0;
      end
      S_RUN: begin
        if (r_k == c_klast) begin
          w_state_nxt = S_DRAIN;
          w_d_nxt     = '0;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_d == c_dlast) begin
          w_state_nxt = S_LATCH;
        end else begin
          w_d_nxt = r_d + 1'b1;
        end
      end
      S_LATCH: begin
        case (r_b)
          2'd0:    w_lo_nxt  = w_res;
          2'd1:    w_mid_nxt = w_res;
          default: w_hi_nxt  = w_res;
        endcase
        if (r_b == c_blast) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
          w_b_nxt     = r_b + 2'd1;
          w_k_nxt     = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Any cycle spent in RUN issues one MAC operation for tap k of band b;
    // the newest sample sits at p, older ones walk backwards through the ring.
    if (w_state_nxt == S_RUN) begin
      w_mac_en_nxt     = 1'b1;
      w_mac_clr_nxt    = (w_k_nxt == '0);
      w_hist_raddr_nxt = r_p - w_k_nxt;
      w_coef_addr_nxt  = {w_b_nxt, w_k_nxt};
      w_tap_valid_nxt  = ({1'b0, w_k_nxt} < w_fill_nxt);
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_bank_sequencer
//  Description : Self-checking bench for filter_bank_sequencer with a
//                behavioural history RAM, coefficient ROM and 2-cycle MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_bank_sequencer;

  localparam int WIDTH   = 25;
  localparam int NTAPS   = 8;
  localparam int AW      = 3;
  localparam int MAC_LAT = 2;
  localparam int ACCW    = 53;

  logic              clock44k = 1'b0;
  logic              reset    = 1'b1;
  logic              enable   = 1'b0;
  logic              busy, overrun, hist_we, tap_valid, mac_en, mac_clr, done;
  logic [AW-1:0]     hist_waddr, hist_raddr;
  logic [AW+1:0]     coef_addr;
  logic [ACCW-1:0]   acc = '0;
  logic [WIDTH-1:0]  ykbajos, ykmedios, ykaltos;

  logic [WIDTH-1:0]  hmem [NTAPS];
  logic [WIDTH-1:0]  coef [4*NTAPS];
  logic [WIDTH-1:0]  wdata = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_wptr = 0;
  int exp_fill = 0;

  always #5 clock44k = ~clock44k;

  filter_bank_sequencer #(
    .WIDTH(WIDTH), .NTAPS(NTAPS), .AW(AW), .MAC_LAT(MAC_LAT), .ACCW(ACCW)
  ) dut (
    .clock44k  (clock44k),
    .reset     (reset),
    .enable    (enable),
    .busy      (busy),
    .overrun   (overrun),
    .hist_we   (hist_we),
    .hist_waddr(hist_waddr),
    .hist_raddr(hist_raddr),
    .tap_valid (tap_valid),
    .coef_addr (coef_addr),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .acc       (acc),
    .ykbajos   (ykbajos),
    .ykmedios  (ykmedios),
    .ykaltos   (ykaltos),
    .done      (done)
  );

  // Behavioural MAC: operand product registered once, folded into acc on the
  // following edge, giving a two-cycle mac_en-to-acc latency.
  logic signed [ACCW-1:0] ea, eb, prod;
  logic signed [ACCW-1:0] s1_p = '0;
  logic                   s1_v = 1'b0;
  logic                   s1_c = 1'b0;

  always_comb begin
    ea   = {{(ACCW-WIDTH){hmem[hist_raddr][WIDTH-1]}}, hmem[hist_raddr]};
    eb   = {{(ACCW-WIDTH){coef[coef_addr][WIDTH-1]}}, coef[coef_addr]};
    prod = tap_valid ? ea * eb : '0;
  end

  always @(posedge clock44k) begin
    if (hist_we) hmem[hist_waddr] <= wdata;
    s1_v <= mac_en;
    s1_c <= mac_clr;
    s1_p <= prod;
    if (s1_v) acc <= s1_c ? s1_p : acc + s1_p;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_coefs(input int ph);
    for (int i = 0; i < 4*NTAPS; i++) begin
      if (ph == 0) begin
        case (i / NTAPS)
          0:       coef[i] = 25'h0800000;
          1:       coef[i] = 25'h0400000;
          2:       coef[i] = 25'h1800000;
          default: coef[i] = 25'h0;
        endcase
      end else begin
        coef[i] = 25'h0FFFFFF;
      end
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    @(posedge clock44k); #1;
    reset    = 1'b0;
    exp_wptr = 0;
    exp_fill = 0;
  endtask

  // Expected schedule for cycle A+n of one sample; lvl 2 also checks when
  // each band result first appears (only valid for an impulse after reset).
  task automatic check_cycle(input int n, input int p, input int fl, input int lvl);
    int b, off, k;
    if (n == 1) begin
      chk($sformatf("busy@%0d", n), 64'(busy), 64'd1);
      chk($sformatf("mac_en@%0d", n), 64'(mac_en), 64'd0);
    end else if (n == 35) begin
      chk($sformatf("done@%0d", n), 64'(done), 64'd1);
      chk($sformatf("busy@%0d", n), 64'(busy), 64'd0);
      chk($sformatf("mac_en@%0d", n), 64'(mac_en), 64'd0);
    end else begin
      b   = (n - 2) / 11;
      off = (n - 2) % 11;
      chk($sformatf("busy@%0d", n), 64'(busy), 64'd1);
      chk($sformatf("done@%0d", n), 64'(done), 64'd0);
      if (off < NTAPS) begin
        k = off;
        chk($sformatf("mac_en@%0d", n), 64'(mac_en), 64'd1);
        chk($sformatf("mac_clr@%0d", n), 64'(mac_clr), 64'(k == 0));
        chk($sformatf("raddr@%0d", n), 64'(hist_raddr), 64'((p - k + NTAPS) % NTAPS));
        chk($sformatf("coef_addr@%0d", n), 64'(coef_addr), 64'(b*NTAPS + k));
        chk($sformatf("tap_valid@%0d", n), 64'(tap_valid), 64'(k < fl));
      end else begin
        chk($sformatf("mac_en@%0d", n), 64'(mac_en), 64'd0);
      end
    end
    if (lvl == 2) begin
      case (n)
        12: chk("ykbajos@12",  64'(ykbajos),  64'h0);
        13: chk("ykbajos@13",  64'(ykbajos),  64'h0400000);
        23: chk("ykmedios@23", 64'(ykmedios), 64'h0);
        24: chk("ykmedios@24", 64'(ykmedios), 64'h0200000);
        34: chk("ykaltos@34",  64'(ykaltos),  64'h0);
        35: chk("ykaltos@35",  64'(ykaltos),  64'h1C00000);
        default: ;
      endcase
    end
  endtask

  // Issues one sample in the current cycle (A) and follows it to done.
  // ovr_at > 0 raises a stray enable during cycle A+ovr_at.
  task automatic do_sample(input logic [WIDTH-1:0] s, input int lvl, input int ovr_at);
    int  n, p, fl;
    bit  seen;
    p        = exp_wptr;
    exp_wptr = (exp_wptr + 1) % NTAPS;
    if (exp_fill < NTAPS) exp_fill++;
    fl       = exp_fill;
    wdata    = s;
    enable   = 1'b1;
    @(posedge clock44k); #1;
    enable = 1'b0;
    chk("hist_we@1", 64'(hist_we), 64'd1);
    chk("hist_waddr@1", 64'(hist_waddr), 64'(p));
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 60) begin
      if (lvl > 0) check_cycle(n, p, fl, lvl);
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clock44k); #1;
        n++;
        enable = (ovr_at != 0 && n == ovr_at);
      end
    end
    enable = 1'b0;
    chk("done_latency", 64'(n), 64'd35);
  endtask

  typedef struct {
    int               phase;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] hi;
  } vec_t;

  vec_t tv [25];

  task automatic setv(input int i, input int ph, input logic [WIDTH-1:0] s,
                      input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] mid,
                      input logic [WIDTH-1:0] hi);
    tv[i].phase = ph;
    tv[i].s     = s;
    tv[i].lo    = lo;
    tv[i].mid   = mid;
    tv[i].hi    = hi;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  prev_phase;
    bit  saw_done;

    // Impulse: 0.5 into taps of 0.5 / 0.25 / -0.5 per band.
    setv(0, 0, 25'h0800000, 25'h0400000, 25'h0200000, 25'h1C00000);
    for (int i = 1; i < 8; i++) setv(i, 0, 25'h0, 25'h0400000, 25'h0200000, 25'h1C00000);
    setv(8, 0, 25'h0, 25'h0, 25'h0, 25'h0);
    // Saturation: all coefficients just below +1.
    setv(9, 1, 25'h0FFFFFF, 25'h0FFFFFE, 25'h0FFFFFE, 25'h0FFFFFE);
    for (int i = 10; i < 17; i++) setv(i, 1, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF);
    for (int i = 17; i < 20; i++) setv(i, 1, 25'h1000000, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF);
    setv(20, 1, 25'h1000000, 25'h1FFFFFC, 25'h1FFFFFC, 25'h1FFFFFC);
    for (int i = 21; i < 25; i++) setv(i, 1, 25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000);

    set_coefs(0);

    // Reset state
    repeat (2) @(posedge clock44k);
    #1;
    chk("rst_busy",     64'(busy),       64'd0);
    chk("rst_overrun",  64'(overrun),    64'd0);
    chk("rst_done",     64'(done),       64'd0);
    chk("rst_hist_we",  64'(hist_we),    64'd0);
    chk("rst_mac_en",   64'(mac_en),     64'd0);
    chk("rst_coef",     64'(coef_addr),  64'd0);
    chk("rst_waddr",    64'(hist_waddr), 64'd0);
    chk("rst_ykbajos",  64'(ykbajos),    64'd0);
    chk("rst_ykmedios", 64'(ykmedios),   64'd0);
    chk("rst_ykaltos",  64'(ykaltos),    64'd0);
    reset = 1'b0;

    // Single sample after reset: full schedule and result timing
    do_sample(25'h0800000, 2, 0);

    // Table-driven impulse and saturation runs
    prev_phase = -1;
    for (int i = 0; i < 25; i++) begin
      if (tv[i].phase != prev_phase) begin
        set_coefs(tv[i].phase);
        do_reset();
        prev_phase = tv[i].phase;
      end
      do_sample(tv[i].s, 0, 0);
      chk($sformatf("ykbajos[v%0d]", i),  64'(ykbajos),  64'(tv[i].lo));
      chk($sformatf("ykmedios[v%0d]", i), 64'(ykmedios), 64'(tv[i].mid));
      chk($sformatf("ykaltos[v%0d]", i),  64'(ykaltos),  64'(tv[i].hi));
    end
    chk("overrun_clear", 64'(overrun), 64'd0);

    // Overrun, wrap and back-to-back: nine samples, stray enable at A+10
    set_coefs(0);
    do_reset();
    for (int j = 0; j < 9; j++) begin
      do_sample((j == 0) ? 25'h0800000 : 25'h0, 1, (j == 0) ? 10 : 0);
      if (j == 0) chk("overrun_set", 64'(overrun), 64'd1);
    end
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("wrap_ykbajos",   64'(ykbajos), 64'h0);

    // Asynchronous reset mid-cycle during RUN (A+5)
    wdata  = 25'h0800000;
    enable = 1'b1;
    @(posedge clock44k); #1;
    enable = 1'b0;
    repeat (4) begin
      @(posedge clock44k); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_busy",      64'(busy),       64'd0);
    chk("mid_overrun",   64'(overrun),    64'd0);
    chk("mid_mac_en",    64'(mac_en),     64'd0);
    chk("mid_tap_valid", 64'(tap_valid),  64'd0);
    chk("mid_coef",      64'(coef_addr),  64'd0);
    chk("mid_raddr",     64'(hist_raddr), 64'd0);
    chk("mid_ykbajos",   64'(ykbajos),    64'd0);
    chk("mid_ykaltos",   64'(ykaltos),    64'd0);
    @(posedge clock44k); #1;
    reset    = 1'b0;
    exp_wptr = 0;
    exp_fill = 0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock44k); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("mid_no_done", 64'(saw_done), 64'd0);
    do_sample(25'h0800000, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
